// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_pkg : shared AHB-Lite encodings and SRAM-slave FSM state codes    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WAIT = 3'd1;
  localparam state_t ST_DATA = 3'd2;
  localparam state_t ST_ERR1 = 3'd3;
  localparam state_t ST_ERR2 = 3'd4;

  function automatic logic size_misaligned(input logic [2:0] size, input logic [1:0] lo);
    return ((size == HSIZE_HALF) && lo[0]) || ((size == HSIZE_WORD) && (lo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_sram_array : MEM_WORDS x 32 SRAM, byte-enable write port and      |
// | registered read port. Rev 1.0                                        |
// +----------------------------------------------------------------------+
module ahb_sram_array #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdata_q;

  // Read-first: a same-cycle write to the read word returns the old contents.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ahb3lite_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb3lite_sram_slave : AHB-Lite SRAM responder with wait states,       |
// | byte strobes, two-cycle ERROR and read-after-write forwarding. Rev 1.0|
// +----------------------------------------------------------------------+
module ahb3lite_sram_slave import ahb_pkg::*; #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic [DATA_W-1:0]   HWDATA,
  input  logic [DATA_W/8-1:0] HWSTRB,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic [DATA_W-1:0]   HRDATA,
  output logic                HRESP
);

  localparam int          c_aw        = $clog2(MEM_WORDS);
  localparam int          c_nb        = DATA_W / 8;
  localparam logic [3:0]  c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                state_q, state_d;
  logic [c_aw-1:0]       addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [3:0]            wcnt_q;
  logic                  fwd_q;
  logic [DATA_W-1:0]     fwd_data_q;
  logic [c_nb-1:0]       fwd_strb_q;
  logic [DATA_W-1:0]     hrdata_q;

  logic                  w_accept, w_start, w_err, w_we, w_re, w_fwd;
  logic [c_nb-1:0]       w_be;
  logic [c_aw-1:0]       w_raddr;
  logic [DATA_W-1:0]     w_mem_rdata, w_merged;
  logic                  w_hreadyout, w_hresp;
  logic                  w_unused;

  assign w_accept = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign w_start  = w_accept && ((state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2));
  assign w_err    = ((HADDR >> (c_aw + 2)) != '0) || (HSIZE > HSIZE_WORD) ||
                    size_misaligned(HSIZE, HADDR[1:0]);
  assign w_raddr  = HADDR[c_aw+1:2];
  assign w_we     = (state_q == ST_DATA) && write_q;
  assign w_be     = HWSTRB & {c_nb{w_we}};
  assign w_re     = w_start && !w_err && !HWRITE;
  // The array returns the pre-write word, so a colliding read remembers the lanes to patch in.
  assign w_fwd    = w_re && w_we && (w_raddr == addr_q);
  assign w_unused = ^{HBURST, size_q};

  ahb_sram_array #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (c_aw)
  ) u_array (
    .clk_i   (HCLK),
    .we_i    (w_be),
    .waddr_i (addr_q),
    .wdata_i (HWDATA),
    .re_i    (w_re),
    .raddr_i (w_raddr),
    .rdata_o (w_mem_rdata)
  );

  always_comb begin
    w_merged = w_mem_rdata;
    for (int i = 0; i < c_nb; i++) begin
      if (fwd_q && fwd_strb_q[i]) w_merged[8*i +: 8] = fwd_data_q[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (!w_start)              state_d = ST_IDLE;
        else if (w_err)            state_d = ST_ERR1;
        else if (WAIT_STATES > 0)  state_d = ST_WAIT;
        else                       state_d = ST_DATA;
      end
      ST_WAIT: if (wcnt_q == 4'd0) state_d = ST_DATA;
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_hreadyout = 1'b1;
    w_hresp     = HRESP_OKAY;
    case (state_q)
      ST_WAIT: w_hreadyout = 1'b0;
      ST_ERR1: begin w_hreadyout = 1'b0; w_hresp = HRESP_ERROR; end
      ST_ERR2: w_hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      wcnt_q     <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      fwd_strb_q <= '0;
      hrdata_q   <= '0;
    end else begin
      if ((state_q == ST_DATA) && !write_q) hrdata_q <= w_merged;
      if (w_start) begin
        addr_q     <= w_raddr;
        write_q    <= HWRITE;
        size_q     <= HSIZE;
        wcnt_q     <= c_wait_load;
        fwd_q      <= w_fwd;
        fwd_data_q <= HWDATA;
        fwd_strb_q <= HWSTRB;
      end else if ((state_q == ST_WAIT) && (wcnt_q != 4'd0)) begin
        wcnt_q <= wcnt_q - 4'd1;
      end
    end
  end

  assign HREADYOUT = w_hreadyout;
  assign HRESP     = w_hresp;
  assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? w_merged : hrdata_q;

endmodule
`default_nettype wire

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
- AHB-Lite responder (slave) with on-chip word-organised SRAM. It is the far end of the CPU-to-AHB master adapter's bus.
- Serves single and burst (SEQ) transfers with byte strobes, a configurable number of wait states, and a two-cycle ERROR response.
- Sits on the AHB-Lite segment beside the AHB-to-APB bridge. It gives the core a zero-to-N-wait data/scratch memory that does not cross into the APB domain.

Parameters:
- ADDR_W, 32, HADDR width
- DATA_W, 32, data width; fixed at 32 for this revision
- MEM_WORDS, 1024, SRAM depth in 32-bit words; power of two
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per accepted transfer (0..15)

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL  in  1  slave select from address decoder
- HADDR  in  ADDR_W  byte address (address phase)
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1=write
- HSIZE  in  3  transfer size; 0/1/2 legal
- HBURST  in  3  burst type; informational only, not used for decisions
- HWDATA  in  32  write data (data phase)
- HWSTRB  in  4  byte write strobes (data phase)
- HREADY  in  1  bus-level ready (previous transfer completing)
- HREADYOUT  out  1  this slave's ready
- HRDATA  out  32  read data
- HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (async, HRESETn=0): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, pending-write flag cleared. A write in its data phase is dropped. SRAM contents are not reset.
- Accept condition: HSEL & HREADY & HTRANS[1]. On accept, register HADDR word index, HWRITE and HSIZE; move to the data phase.
- IDLE/BUSY with HSEL=1, or HSEL=0: no accept. The next cycle is a zero-wait OKAY with no memory side effect.
- Error check at accept time. Any one of these makes an error transfer:
  - word index >= MEM_WORDS
  - HSIZE > 2
  - misalignment: HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]!=0
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Good accept goes to WAIT if WAIT_STATES>0, else to DATA. Error accept goes to ERR1.
  - WAIT: HREADYOUT=0. A counter loads WAIT_STATES-1 on accept and decrements each cycle; at 0, go to DATA.
  - DATA: HREADYOUT=1, HRESP=0. Completion cycle.
    - Read: HRDATA holds the full word.
    - Write: commit HWDATA lanes where HWSTRB[i]=1. HWSTRB=0000 is a legal no-op.
    - A new accept in this cycle is pipelined: go to WAIT, DATA or ERR1 as above. Otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Next state is ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No write occurs. A new accept is honoured as in DATA; otherwise go to IDLE.
- Read latency: SRAM read is synchronous. The read address is issued on the accept cycle, so data is available in the first data-phase cycle. Total latency is 1+WAIT_STATES cycles from accept to completion.
- HRDATA: updated only in the DATA state for reads. It holds its last value otherwise.
- Read-after-write forwarding: a read accepted in the same cycle that a write completes to the same word returns the merged word: new bytes per HWSTRB, old bytes otherwise. It never returns stale data.
- Address wrap: none. Only word index bits [log2(MEM_WORDS)+1:2] address the array. Upper bits are checked for range, not aliased.
- Back-to-back SEQ beats: sustained one beat per cycle when WAIT_STATES=0.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings
  - HRESP_OKAY/ERROR
  - HSIZE_BYTE/HALF/WORD
  - FSM state encoding (IDLE, WAIT, DATA, ERR1, ERR2)
- One sub-module: ahb_sram_array. One write port with 4 byte enables and one synchronous read port, MEM_WORDS x 32, inferable as block RAM. The forwarding mux stays in the parent.

Test Plan:
- Write-then-read: NONSEQ write 0x0000_0010 <- 0xDEADBEEF with HWSTRB=1111, then NONSEQ read of 0x10. Required: HRDATA=0xDEADBEEF, HRESP=0, both transfers zero-wait (WAIT_STATES=0).
- Byte strobes: preload 0x11223344 at 0x20, write 0xAABBCCDD with HWSTRB=0101. Read must return 0x11BB33DD.
- Forwarding: write 0x12345678 to 0x30 with a read of 0x30 accepted in the same cycle as the write data phase. Read returns 0x12345678.
- Wait states (WAIT_STATES=3): single read. Required: HREADYOUT low for exactly 3 cycles, then high with valid data. An INCR4 burst takes 16 cycles total.
- Error: read at word index MEM_WORDS (0x1000 with 1024 words), and separately a misaligned word write at 0x02. Required: HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; memory unchanged at 0x00.
- Reset mid-transfer: assert HRESETn=0 during WAIT of a write to 0x40. Required: HREADYOUT=1 and HRESP=0 immediately; old contents at 0x40 intact after release.
